// File: rtl/param_swap_regfile.sv
// -----------------------------------------------------------------------------
// param_swap_regfile
//
// Purpose:
//   DEPTH x WIDTH register file driven by a small command interface. Supported
//   commands are a single-cycle write, a two-cycle swap of two registers and,
//   optionally, a single-cycle in-place add. An init command reloads every
//   register with its own index (mod 2^WIDTH) and aborts any swap in flight.
//
// Configuration macro:
//   RF_ADD_OP_EN - when defined, op_code 2'b10 is an add:
//                  r[addr_x] <= r[addr_x] + r[addr_y], with the carry dropped.
//                  When undefined, 2'b10 is treated as an illegal opcode and
//                  no adder is built.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous, active-high reset
//   init       in   synchronous reload of all registers with their index
//   op_valid   in   command request
//   op_ready   out  command accepted when op_valid && op_ready at an edge
//   op_code    in   00 write, 01 swap, 10 add (optional), 11 illegal
//   addr_x     in   first operand / destination index
//   addr_y     in   second operand index
//   wr_data    in   write data
//   rd_addr_a  in   read port A index
//   rd_addr_b  in   read port B index
//   rd_data_a  out  combinational r[rd_addr_a]
//   rd_data_b  out  combinational r[rd_addr_b]
//   regs_flat  out  all registers, register i at [i*WIDTH +: WIDTH]
//   done       out  one-cycle pulse after a legal operation commits
//   err        out  one-cycle pulse after an illegal opcode is accepted
// -----------------------------------------------------------------------------
module param_swap_regfile #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_code,
  input  logic [AW-1:0]          addr_x,
  input  logic [AW-1:0]          addr_y,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic [AW-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b,
  output logic [WIDTH*DEPTH-1:0] regs_flat,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SWAP = 1'b1
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_SWAP    = 2'b01;
  localparam logic [1:0] OP_ADD     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Value a register takes on reset or init: its own index, truncated.
  function automatic logic [WIDTH-1:0] index_value(input int idx);
    return WIDTH'(idx);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] tmp_x_q, tmp_x_d;
  logic [WIDTH-1:0] tmp_y_q, tmp_y_d;
  logic [AW-1:0]    swap_x_q, swap_x_d;
  logic [AW-1:0]    swap_y_q, swap_y_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef RF_ADD_OP_EN
  logic [WIDTH-1:0] add_sum;
  // Carry out is intentionally discarded: the sum wraps mod 2^WIDTH.
  assign add_sum = regs_q[addr_x] + regs_q[addr_y];
`endif

  // State register: all flops, synchronous reset to the index pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= index_value(i);
      end
      tmp_x_q  <= '0;
      tmp_y_q  <= '0;
      swap_x_q <= '0;
      swap_y_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      tmp_x_q  <= tmp_x_d;
      tmp_y_q  <= tmp_y_d;
      swap_x_q <= swap_x_d;
      swap_y_q <= swap_y_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: command decode, swap sequencing and init override.
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    tmp_x_d  = tmp_x_q;
    tmp_y_d  = tmp_y_q;
    swap_x_d = swap_x_q;
    swap_y_d = swap_y_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (init) begin
      // Init wins over everything: a pending swap is dropped without its
      // write-back and no done/err is reported for it.
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = index_value(i);
      end
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // op_ready is just "IDLE and no init" here, so op_valid alone accepts.
          if (op_valid) begin
            case (op_code)
              OP_WRITE: begin
                regs_d[addr_x] = wr_data;
                done_d         = 1'b1;
              end
              OP_SWAP: begin
                tmp_x_d  = regs_q[addr_x];
                tmp_y_d  = regs_q[addr_y];
                swap_x_d = addr_x;
                swap_y_d = addr_y;
                state_d  = ST_SWAP;
              end
`ifdef RF_ADD_OP_EN
              OP_ADD: begin
                regs_d[addr_x] = add_sum;
                done_d         = 1'b1;
              end
`else
              OP_ADD: begin
                err_d = 1'b1;
              end
`endif
              OP_ILLEGAL: begin
                err_d = 1'b1;
              end
              default: begin
                err_d = 1'b1;
              end
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SWAP: begin
          // With equal addresses both writes target one register and both
          // temporaries hold the same value, so the register is unchanged.
          regs_d[swap_x_q] = tmp_y_q;
          regs_d[swap_y_q] = tmp_x_q;
          done_d           = 1'b1;
          state_d          = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic: handshake and combinational read ports (no write bypass).
  always_comb begin
    op_ready  = (state_q == ST_IDLE) && !init;
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    done      = done_q;
    err       = err_q;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_param_swap_regfile.sv
// Self-checking bench for param_swap_regfile at WIDTH=4, DEPTH=8.
// A reference model of the register file predicts each command's outcome;
// predictions are queued when the command is driven and compared when the
// DUT pulses done or err.
module tb_param_swap_regfile;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;
`ifdef RF_ADD_OP_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            init;
  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_code;
  logic [AW-1:0]   addr_x;
  logic [AW-1:0]   addr_y;
  logic [W-1:0]    wr_data;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic [W-1:0]    rd_data_a;
  logic [W-1:0]    rd_data_b;
  logic [W*D-1:0]  regs_flat;
  logic            done;
  logic            err;

  param_swap_regfile #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .init(init), .op_valid(op_valid),
    .op_ready(op_ready), .op_code(op_code), .addr_x(addr_x), .addr_y(addr_y),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .regs_flat(regs_flat),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           is_err;
    int             lat;
    int             x;
    logic [W*D-1:0] flat;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m [D];
  int           checks;
  int           errors;

  function automatic logic [W*D-1:0] model_flat();
    logic [W*D-1:0] f;
    for (int i = 0; i < D; i++) f[i*W +: W] = m[i];
    return f;
  endfunction

  task automatic model_init();
    for (int i = 0; i < D; i++) m[i] = W'(i);
  endtask

  // Waits for the queued operation's done/err pulse and checks it.
  task automatic wait_result();
    exp_t e;
    int   lat;
    bit   seen;
    e    = exp_q.pop_front();
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 4 && !seen; c++) begin
      @(negedge clk);
      if (e.lat == 2 && c == 1) begin
        checks++;
        if (op_ready !== 1'b0) begin
          errors++;
          $display("FAIL swap_busy_ready: got %b expected 0", op_ready);
        end
      end
      if (done === 1'b1 || err === 1'b1) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL result_timeout: no done/err within 4 cycles, expected latency %0d", e.lat);
    end else begin
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL latency: got %0d expected %0d", lat, e.lat);
      end
      checks++;
      if (err !== e.is_err || done !== !e.is_err) begin
        errors++;
        $display("FAIL pulse_kind: got done=%b err=%b expected err=%b", done, err, e.is_err);
      end
      checks++;
      if (regs_flat !== e.flat) begin
        errors++;
        $display("FAIL regs_flat: got %h expected %h", regs_flat, e.flat);
      end
      checks++;
      if (rd_data_a !== e.flat[e.x*W +: W]) begin
        errors++;
        $display("FAIL read_after: got %h expected %h", rd_data_a, e.flat[e.x*W +: W]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: got done=%b err=%b expected 0 0", done, err);
      end
    end
  endtask

  // Drives one command, predicts its effect, then checks the result.
  task automatic do_op(input logic [1:0] op, input int x, input int y, input logic [W-1:0] d);
    exp_t         e;
    logic [W-1:0] tx;
    logic [W-1:0] ty;
    @(negedge clk);
    op_valid  = 1'b1;
    op_code   = op;
    addr_x    = AW'(x);
    addr_y    = AW'(y);
    wr_data   = d;
    rd_addr_a = AW'(x);
    rd_addr_b = AW'(y);
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle: got %b expected 1", op_ready);
    end
    checks++;
    if (rd_data_a !== m[x] || rd_data_b !== m[y]) begin
      errors++;
      $display("FAIL read_pre: got %h %h expected %h %h", rd_data_a, rd_data_b, m[x], m[y]);
    end
    e.is_err = 1'b0;
    e.lat    = 1;
    e.x      = x;
    if (op == 2'b00) begin
      m[x] = d;
    end else if (op == 2'b01) begin
      tx   = m[x];
      ty   = m[y];
      m[x] = ty;
      m[y] = tx;
      e.lat = 2;
    end else if (op == 2'b10 && ADD_EN) begin
      m[x] = W'(m[x] + m[y]);
    end else begin
      e.is_err = 1'b1;
    end
    e.flat = model_flat();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    wait_result();
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    model_init();
  endtask

  task automatic check_quiet_index(input string name);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL %s_quiet: got done=%b err=%b expected 0 0", name, done, err);
      end
    end
    checks++;
    if (regs_flat !== 32'h7654_3210) begin
      errors++;
      $display("FAIL %s_regs: got %h expected 76543210", name, regs_flat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b1; op_valid = 1'b1; op_code = 2'b00;
    addr_x = 3'd3; addr_y = 3'd0; wr_data = 4'hF; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_init();
    checks++;
    if (regs_flat !== 32'h7654_3210 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got regs=%h done=%b err=%b expected 76543210 0 0", regs_flat, done, err);
    end
    reset = 1'b0; init = 1'b0; op_valid = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", op_ready);
    end
    check_quiet_index("post_reset");
  endtask

  task automatic test_init();
    do_op(2'b00, 0, 0, 4'h9);
    do_op(2'b00, 5, 0, 4'hC);
    do_init();
    @(negedge clk);
    checks++;
    if (regs_flat !== 32'h7654_3210 || op_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL init_state: got regs=%h ready=%b done=%b err=%b expected 76543210 1 0 0",
               regs_flat, op_ready, done, err);
    end
  endtask

  task automatic test_swap();
    do_op(2'b01, 2, 5, 4'h0);
    checks++;
    if (regs_flat !== 32'h7624_3510) begin
      errors++;
      $display("FAIL swap_2_5: got %h expected 76243510", regs_flat);
    end
    do_init();
  endtask

  task automatic test_self_swap();
    do_op(2'b00, 7, 0, 4'hA);
    do_op(2'b01, 7, 7, 4'h0);
    checks++;
    if (regs_flat !== 32'hA654_3210) begin
      errors++;
      $display("FAIL self_swap: got %h expected a6543210", regs_flat);
    end
  endtask

  task automatic test_init_abort();
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b01; addr_x = 3'd1; addr_y = 3'd6;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept_ready: got %b expected 1", op_ready);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    init     = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    model_init();
    check_quiet_index("init_abort");
  endtask

  task automatic test_illegal_and_add();
    do_op(2'b11, 2, 3, 4'h5);
    do_op(2'b00, 3, 0, 4'hF);
    do_op(2'b00, 4, 0, 4'h4);
    do_op(2'b10, 3, 4, 4'h0);
    checks++;
    if (regs_flat[15:12] !== (ADD_EN ? 4'h3 : 4'hF) || regs_flat[19:16] !== 4'h4) begin
      errors++;
      $display("FAIL add_r3_r4: got r3=%h r4=%h expected r3=%h r4=4",
               regs_flat[15:12], regs_flat[19:16], (ADD_EN ? 4'h3 : 4'hF));
    end
  endtask

  task automatic test_init_priority();
    @(negedge clk);
    init = 1'b1; op_valid = 1'b1; op_code = 2'b11; addr_x = 3'd2;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL init_prio_ready: got %b expected 0", op_ready);
    end
    @(posedge clk);
    #1;
    init = 1'b0; op_valid = 1'b0;
    model_init();
    check_quiet_index("init_priority");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++) begin
      do_op(2'($urandom_range(0, 3)), int'($urandom_range(0, D-1)),
            int'($urandom_range(0, D-1)), W'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_init();
    test_swap();
    test_self_swap();
    test_init_abort();
    test_illegal_and_add();
    test_init_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
